// File: rtl/alu_sequencer.sv
// Sequences one ALU operation: BEGIN strobe, operand loads, wait for END, then hold the result.
// Optional WAIT watchdog with abort pulse is enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [7:0]  req_opa,
    input  logic [7:0]  req_opq,
    input  logic [7:0]  req_opm,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        alu_begin,
    output logic [1:0]  alu_op,
    output logic [7:0]  alu_inbus,
    input  logic [7:0]  alu_outbus,
    input  logic        alu_end,
    output logic        alu_abort,
    output logic        busy
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StLoadA,
        StLoadQ,
        StLoadM,
        StWait,
        StHold
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  op_q;
    logic [7:0]  opa_q, opq_q, opm_q;
    logic [7:0]  prev_out_q;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        accept;
    logic        end_seen;
    logic        timeout;

    assign accept   = req_valid && (state_q == StIdle);
    assign end_seen = (state_q == StWait) && alu_end;

`ifdef ALU_SEQ_TIMEOUT_EN
    logic [5:0] wdog_q;

    // Held at zero outside WAIT, so every WAIT entry starts from a cleared count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_q <= 6'd0;
        end else if (state_q != StWait) begin
            wdog_q <= 6'd0;
        end else if (!alu_end) begin
            wdog_q <= wdog_q + 6'd1;
        end
    end

    assign timeout = (state_q == StWait) && !alu_end && (wdog_q == 6'd63);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StStart;
            StStart: state_d = (op_q == 2'b11) ? StLoadA : StLoadQ;
            StLoadA: state_d = StLoadQ;
            StLoadQ: state_d = StLoadM;
            StLoadM: state_d = StWait;
            StWait:  if (end_seen || timeout) state_d = StHold;
            StHold:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q       <= 2'b00;
            opa_q      <= 8'h00;
            opq_q      <= 8'h00;
            opm_q      <= 8'h00;
            prev_out_q <= 8'h00;
            rsp_data_q <= 16'h0000;
            rsp_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= req_op;
                opa_q <= req_opa;
                opq_q <= req_opq;
                opm_q <= req_opm;
            end
            prev_out_q <= alu_outbus;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // A real END wins over a watchdog expiry in the same cycle.
    always_comb begin
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        if (end_seen) begin
            rsp_data_d = {prev_out_q, alu_outbus};
            rsp_err_d  = 1'b0;
        end else if (timeout) begin
            rsp_data_d = 16'h0000;
            rsp_err_d  = 1'b1;
        end
    end

    always_comb begin
        req_ready = (state_q == StIdle);
        busy      = (state_q != StIdle);
        rsp_valid = (state_q == StHold);
        alu_begin = (state_q == StStart);
        alu_op    = (state_q == StIdle) ? 2'b00 : op_q;
        alu_abort = timeout;
        rsp_data  = rsp_data_q;
        rsp_err   = rsp_err_q;
        alu_inbus = 8'h00;
        unique case (state_q)
            StLoadA: alu_inbus = opa_q;
            StLoadQ: alu_inbus = opq_q;
            StLoadM: alu_inbus = opm_q;
            default: alu_inbus = 8'h00;
        endcase
    end

    // A stalled response must stay put until the consumer takes it.
    assert property (@(posedge clk) disable iff (reset)
        (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_err)));

    assert property (@(posedge clk) disable iff (reset) alu_abort |=> !alu_abort);

endmodule
